// File: rtl/sha256_block_sequencer.sv
// ---------------------------------------------------------------------------
// sha256_block_sequencer
//
// Streams a multi-block, already padded message into a SHA-256 core and hands
// the final digest to a consumer. Sixteen 32-bit words are packed into one
// 512-bit block. The core is then driven with one-cycle pulses: init_iv (first
// block of a message only), init_message and start. The sequencer waits for
// the core to finish before it loads the next block.
//
// Handshake: a word moves on every rising edge where s_valid and s_ready are
// both high. s_ready depends only on the sequencer state and abort, never on
// s_valid. The source holds s_word/s_last stable until the transfer.
// digest_valid stays high until a cycle with digest_ack high.
//
// Ports
//   io_mainClk, io_systemReset   clock, asynchronous active-high reset
//   s_word/s_valid/s_last        message word stream in
//   s_ready                      word accepted this cycle
//   abort                        synchronous abort, highest priority
//   core_input_data              packed 512-bit block to the core
//   core_init_iv/_message/start  one-cycle control pulses to the core
//   core_cmd                     CMD_VALUE while the sequencer owns the core
//   core_busy, core_output_data  core status and digest
//   digest/digest_valid          captured final digest, held until ack
//   digest_ack                   consumer acknowledge (used only in DONE)
//   block_count                  blocks completed in the current message
//   error                        sticky busy-rise timeout flag
// ---------------------------------------------------------------------------
module sha256_block_sequencer #(
    parameter int         RISE_TIMEOUT = 16,
    parameter logic [2:0] CMD_VALUE    = 3'd1,
    parameter int         CNT_W        = 16
) (
    input  logic             io_mainClk,
    input  logic             io_systemReset,
    input  logic [31:0]      s_word,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    input  logic             abort,
    output logic [511:0]     core_input_data,
    output logic             core_init_iv,
    output logic             core_init_message,
    output logic             core_start,
    output logic [2:0]       core_cmd,
    input  logic             core_busy,
    input  logic [255:0]     core_output_data,
    output logic [255:0]     digest,
    output logic             digest_valid,
    input  logic             digest_ack,
    output logic [CNT_W-1:0] block_count,
    output logic             error
);

    localparam int RISE_W = $clog2(RISE_TIMEOUT + 1);
    // rise_cnt is 0 on the first WAIT_RISE cycle (one cycle after the start
    // pulse). Giving up when it reaches RISE_TIMEOUT-2 makes error appear
    // exactly RISE_TIMEOUT cycles after the start pulse.
    localparam logic [RISE_W-1:0] RISE_LAST = RISE_W'(RISE_TIMEOUT - 2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        IV,
        MSG,
        START,
        WAIT_RISE,
        WAIT_DONE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        idx;
    logic              first_blk;
    logic              last_flag;
    logic [RISE_W-1:0] rise_cnt;
    logic              word_take;
    logic              rise_expired;

    assign word_take    = s_valid & s_ready;
    assign rise_expired = (rise_cnt == RISE_LAST);

    // State register
    always_ff @(posedge io_mainClk or posedge io_systemReset) begin
        if (io_systemReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_next        = state;
        s_ready           = 1'b0;
        core_init_iv      = 1'b0;
        core_init_message = 1'b0;
        core_start        = 1'b0;
        core_cmd          = (state != IDLE) ? CMD_VALUE : 3'd0;

        case (state)
            IDLE: begin
                // The pending word stays on the bus and is taken in LOAD.
                if (s_valid) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // A word offered alongside abort is not taken; it would be
                // thrown away by the abort anyway.
                s_ready = ~abort;
                if (s_valid && (idx == 4'd15)) begin
                    state_next = first_blk ? IV : MSG;
                end
            end
            IV: begin
                core_init_iv = 1'b1;
                state_next   = MSG;
            end
            MSG: begin
                core_init_message = 1'b1;
                state_next        = START;
            end
            START: begin
                core_start = 1'b1;
                state_next = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (core_busy) begin
                    state_next = WAIT_DONE;
                end else if (rise_expired) begin
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!core_busy) begin
                    state_next = last_flag ? DONE : LOAD;
                end
            end
            DONE: begin
                if (digest_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (abort) begin
            state_next = IDLE;
        end
    end

    // Datapath and status registers
    always_ff @(posedge io_mainClk or posedge io_systemReset) begin
        if (io_systemReset) begin
            core_input_data <= '0;
            digest          <= '0;
            digest_valid    <= 1'b0;
            block_count     <= '0;
            error           <= 1'b0;
            idx             <= '0;
            first_blk       <= 1'b1;
            last_flag       <= 1'b0;
            rise_cnt        <= '0;
        end else if (abort) begin
            // core_input_data and digest keep their contents on abort.
            digest_valid <= 1'b0;
            block_count  <= '0;
            error        <= 1'b0;
            idx          <= '0;
            first_blk    <= 1'b1;
            last_flag    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (word_take) begin
                        // ~idx == 15-idx, so word 0 lands in [511:480]
                        // and word 15 in [31:0].
                        core_input_data[{~idx, 5'b0} +: 32] <= s_word;
                        idx <= idx + 4'd1;  // wraps to 0 after word 15
                        if (s_last) begin
                            last_flag <= 1'b1;
                        end
                    end
                end
                IV: begin
                    first_blk <= 1'b0;
                end
                START: begin
                    rise_cnt <= '0;
                end
                WAIT_RISE: begin
                    if (!core_busy) begin
                        if (rise_expired) begin
                            error     <= 1'b1;
                            first_blk <= 1'b1;
                            // The abandoned block must not mark the next
                            // message as final.
                            last_flag <= 1'b0;
                        end else begin
                            rise_cnt <= rise_cnt + RISE_W'(1);
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!core_busy) begin
                        block_count <= block_count + CNT_W'(1);
                        last_flag   <= 1'b0;
                        if (last_flag) begin
                            digest       <= core_output_data;
                            digest_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (digest_ack) begin
                        digest_valid <= 1'b0;
                        first_blk    <= 1'b1;
                        block_count  <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
module tb_sha256_block_sequencer;

    localparam int RISE_TIMEOUT = 16;
    localparam int CNT_W        = 16;
    localparam int CORE_CYCLES  = 64;

    localparam logic [255:0] SHA_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIGEST =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      s_word = '0;
    logic             s_valid = 1'b0;
    logic             s_last = 1'b0;
    logic             s_ready;
    logic             abort = 1'b0;
    logic [511:0]     core_input_data;
    logic             core_init_iv;
    logic             core_init_message;
    logic             core_start;
    logic [2:0]       core_cmd;
    logic             core_busy;
    logic [255:0]     core_output_data;
    logic [255:0]     digest;
    logic             digest_valid;
    logic             digest_ack = 1'b0;
    logic [CNT_W-1:0] block_count;
    logic             error;

    always #5 clk = ~clk;

    sha256_block_sequencer #(
        .RISE_TIMEOUT(RISE_TIMEOUT),
        .CMD_VALUE   (3'd1),
        .CNT_W       (CNT_W)
    ) dut (
        .io_mainClk       (clk),
        .io_systemReset   (rst),
        .s_word           (s_word),
        .s_valid          (s_valid),
        .s_last           (s_last),
        .s_ready          (s_ready),
        .abort            (abort),
        .core_input_data  (core_input_data),
        .core_init_iv     (core_init_iv),
        .core_init_message(core_init_message),
        .core_start       (core_start),
        .core_cmd         (core_cmd),
        .core_busy        (core_busy),
        .core_output_data (core_output_data),
        .digest           (digest),
        .digest_valid     (digest_valid),
        .digest_ack       (digest_ack),
        .block_count      (block_count),
        .error            (error)
    );

    // ---------------- SHA-256 core model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
            t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
            s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    logic         model_busy_en = 1'b1;
    logic         busy_glitch = 1'b0;
    int           model_cnt;
    logic [255:0] model_h;
    logic [511:0] model_blk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_cnt <= 0;
            model_h   <= '0;
            model_blk <= '0;
        end else begin
            if (core_init_iv) model_h <= SHA_IV;
            if (core_init_message) model_blk <= core_input_data;
            if (core_start) begin
                if (model_busy_en) model_cnt <= CORE_CYCLES;
            end else if (model_cnt != 0) begin
                model_cnt <= model_cnt - 1;
                if (model_cnt == 1) model_h <= sha_compress(model_h, model_blk);
            end
        end
    end

    assign core_busy        = (model_cnt != 0) || busy_glitch;
    assign core_output_data = model_h;

    // ---------------- pulse / digest monitor ----------------
    int           cyc = 0;
    int           n_iv = 0, n_msg = 0, n_start = 0, n_bad = 0, dv_rise = 0, start_cyc = 0;
    logic         prev_iv = 1'b0, prev_msg = 1'b0, prev_dv = 1'b0;
    logic [511:0] msg_snap = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ((int'(core_init_iv) + int'(core_init_message) + int'(core_start)) > 1) n_bad <= n_bad + 1;
        else if ((prev_iv && !core_init_message) || (core_start && !prev_msg)) n_bad <= n_bad + 1;
        if (core_init_iv) n_iv <= n_iv + 1;
        if (core_init_message) begin
            n_msg    <= n_msg + 1;
            msg_snap <= core_input_data;
        end
        if (core_start) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
        end
        if (digest_valid && !prev_dv) dv_rise <= dv_rise + 1;
        prev_iv  <= core_init_iv;
        prev_msg <= core_init_message;
        prev_dv  <= digest_valid;
    end

    // ---------------- scoreboard ----------------
    logic [255:0]     exp_q[$];
    logic [CNT_W-1:0] exp_cnt_q[$];
    int               n_checks = 0;
    int               n_pass = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_core_cmd"}, core_cmd, 0);
        check({tag, "_pulses"}, {core_init_iv, core_init_message, core_start}, 0);
        check({tag, "_input_data"}, core_input_data, 0);
        check({tag, "_digest"}, digest, 0);
        check({tag, "_digest_valid"}, digest_valid, 0);
        check({tag, "_block_count"}, block_count, 0);
        check({tag, "_error"}, error, 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [31:0] w, input logic last, input logic gap);
        s_word  = w;
        s_last  = last;
        s_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (s_ready) break;
        end
        if (!s_ready) check("s_ready_wait", s_ready, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_block(input logic [31:0] words [16], input int last_pos, input logic gap);
        for (int i = 0; i < 16; i++) send_word(words[i], (i == last_pos), gap);
    endtask

    task automatic pulse_abort();
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_digest(input string tag);
        logic [255:0]     exp_d;
        logic [CNT_W-1:0] exp_c;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (digest_valid) break;
        end
        check({tag, "_dv_wait"}, digest_valid, 1);
        check({tag, "_exp_q_nonempty"}, (exp_q.size() > 0), 1);
        if (exp_q.size() == 0) return;
        exp_d = exp_q.pop_front();
        exp_c = exp_cnt_q.pop_front();
        check({tag, "_digest"}, digest, exp_d);
        check({tag, "_block_count"}, block_count, exp_c);
        repeat (5) @(negedge clk);
        check({tag, "_dv_held"}, {digest_valid, digest}, {1'b1, exp_d});
        @(posedge clk);
        #1 digest_ack = 1'b1;
        @(posedge clk);
        #1 digest_ack = 1'b0;
        @(negedge clk);
        check({tag, "_after_ack"}, {digest_valid, block_count, core_cmd}, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] abc_blk [16];
    logic [31:0] two_b0 [16];
    logic [31:0] two_b1 [16];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int iv0, msg0, st0, bad0, dv0;

        foreach (abc_blk[i]) begin
            abc_blk[i] = '0;
            two_b0[i]  = '0;
            two_b1[i]  = '0;
        end
        abc_blk[0]  = 32'h61626380;
        abc_blk[15] = 32'h00000018;
        two_b0 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two_b1[15] = 32'h000001c0;

        // Reset state
        #12;
        check_all_zero("reset");
        #5 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_cmd", core_cmd, 0);

        // Single block "abc"
        iv0 = n_iv; msg0 = n_msg; st0 = n_start; bad0 = n_bad;
        exp_q.push_back(ABC_DIGEST); exp_cnt_q.push_back(1);
        send_block(abc_blk, 15, 1'b0);
        wait_digest("abc");
        check("abc_pulse_counts", {n_iv - iv0, n_msg - msg0, n_start - st0}, {32'd1, 32'd1, 32'd1});
        check("abc_pulse_order", n_bad - bad0, 0);

        // Two-block message; s_last on a non-final word of the last block
        iv0 = n_iv; msg0 = n_msg; st0 = n_start; bad0 = n_bad;
        exp_q.push_back(TWO_DIGEST); exp_cnt_q.push_back(2);
        send_block(two_b0, -1, 1'b0);
        send_block(two_b1, 3, 1'b0);
        wait_digest("two");
        check("two_pulse_counts", {n_iv - iv0, n_msg - msg0, n_start - st0}, {32'd1, 32'd2, 32'd2});
        check("two_pulse_order", n_bad - bad0, 0);

        // s_valid toggling, busy glitch during LOAD
        exp_q.push_back(ABC_DIGEST); exp_cnt_q.push_back(1);
        fork
            send_block(abc_blk, 15, 1'b1);
            begin
                repeat (6) @(posedge clk);
                #1 busy_glitch = 1'b1;
                repeat (4) @(posedge clk);
                #1 busy_glitch = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check("toggle_slot0", msg_snap[511:480], abc_blk[0]);
        check("toggle_slot15", msg_snap[31:0], abc_blk[15]);
        wait_digest("toggle");

        // Core never raises busy
        model_busy_en = 1'b0;
        dv0 = dv_rise;
        send_block(abc_blk, 15, 1'b0);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (error) break;
        end
        check("timeout_error", error, 1);
        check("timeout_latency", cyc - start_cyc, RISE_TIMEOUT);
        check("timeout_idle", {core_cmd, s_ready}, 0);
        repeat (3) @(negedge clk);
        check("timeout_sticky", error, 1);
        pulse_abort();
        check("abort_clears_error", error, 0);
        check("timeout_no_digest", dv_rise - dv0, 0);
        model_busy_en = 1'b1;

        // Abort in WAIT_DONE of block 1 of 2, then a fresh message
        dv0 = dv_rise;
        send_block(two_b0, -1, 1'b0);
        send_block(two_b1, 15, 1'b0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (core_busy) break;
        end
        check("abort_busy_seen", core_busy, 1);
        repeat (10) @(negedge clk);
        check("abort_pre_count", block_count, 1);
        pulse_abort();
        check("abort_state", {digest_valid, block_count, core_cmd, s_ready}, 0);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!core_busy) break;
        end
        repeat (5) @(negedge clk);
        check("abort_no_digest", dv_rise - dv0, 0);
        iv0 = n_iv;
        exp_q.push_back(ABC_DIGEST); exp_cnt_q.push_back(1);
        send_block(abc_blk, 15, 1'b0);
        wait_digest("post_abort");
        check("post_abort_iv", n_iv - iv0, 1);

        // Asynchronous reset in the middle of LOAD
        for (int i = 0; i < 5; i++) send_word(two_b0[i], 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst_slot0", core_input_data[511:480], two_b0[0]);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        #2 rst = 1'b0;
        iv0 = n_iv;
        exp_q.push_back(ABC_DIGEST); exp_cnt_q.push_back(1);
        send_block(abc_blk, 15, 1'b0);
        wait_digest("post_rst");
        check("post_rst_iv", n_iv - iv0, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
